// File: rtl/vector100r_deser_if.sv
// Serial-in / parallel-out bus of the word deserializer.
// master drives the serial lane and consumes words; slave is the deserializer.
interface vector100r_deser_if #(parameter int W = 100);
  logic         in_bit;
  logic         in_valid;
  logic         in_start;
  logic         in_ready;
  logic [W-1:0] out;
  logic         out_valid;
  logic         out_ready;
  logic         abort_err;

  modport master (
    output in_bit, in_valid, in_start, out_ready,
    input  in_ready, out, out_valid, abort_err
  );

  modport slave (
    input  in_bit, in_valid, in_start, out_ready,
    output in_ready, out, out_valid, abort_err
  );
endinterface

// File: rtl/vector100r_deser.sv
// Bit-serial to W-bit parallel deserializer with a one-word skid (asm) behind
// the output register, optional bit-order reversal, and restart-on-start abort.
module vector100r_deser #(
  parameter int W       = 100,
  parameter bit REVERSE = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  vector100r_deser_if.slave bus
);
  typedef enum logic {COLLECT, PENDING} state_t;

  localparam logic [6:0] LAST = 7'(W - 1);

  state_t       state;
  logic [6:0]   cnt;
  logic [W-1:0] asm_q, asm_nxt, out_q;
  logic         out_valid_q, rdy_q, abort_q;

  logic       accept, xfer, restart, done, free;
  logic [6:0] idx, pos;

  always_comb begin
    accept  = bus.in_valid && rdy_q;
    xfer    = out_valid_q && bus.out_ready;
    // a start bit mid-word restarts assembly at index 0
    restart = bus.in_start && (cnt != '0);
    idx     = restart ? '0 : cnt;
    pos     = REVERSE ? idx : LAST - idx;
    done    = accept && (idx == LAST);
    free    = !out_valid_q || xfer;
    asm_nxt = asm_q;
    if (accept) asm_nxt[pos] = bus.in_bit;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= COLLECT;
      cnt         <= '0;
      asm_q       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      rdy_q       <= 1'b1;
      abort_q     <= 1'b0;
    end else begin
      abort_q <= accept && restart;
      asm_q   <= asm_nxt;
      case (state)
        COLLECT: begin
          if (accept) cnt <= done ? '0 : idx + 7'd1;
          if (done && free) begin
            out_q       <= asm_nxt;
            out_valid_q <= 1'b1;
          end else if (done) begin
            // output still occupied: park the finished word in asm
            state <= PENDING;
            rdy_q <= 1'b0;
          end else if (xfer) begin
            out_valid_q <= 1'b0;
          end
        end
        PENDING: begin
          if (xfer) begin
            out_q <= asm_q;
            state <= COLLECT;
            rdy_q <= 1'b1;
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

  assign bus.in_ready  = rdy_q;
  assign bus.out       = out_q;
  assign bus.out_valid = out_valid_q;
  assign bus.abort_err = abort_q;
endmodule

// File: tb/tb_vector100r_deser.sv
// Drives one serial stream into a REVERSE=1 and a REVERSE=0 deserializer and
// compares both against a queue-based word model every cycle.
module tb_vector100r_deser;
  localparam int W = 100;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic in_bit = 1'b0, in_valid = 1'b0, in_start = 1'b0, out_ready = 1'b0;

  always #5 clk = ~clk;

  vector100r_deser_if #(.W(W)) if1 ();
  vector100r_deser_if #(.W(W)) if0 ();

  assign if1.in_bit = in_bit;   assign if0.in_bit = in_bit;
  assign if1.in_valid = in_valid; assign if0.in_valid = in_valid;
  assign if1.in_start = in_start; assign if0.in_start = in_start;
  assign if1.out_ready = out_ready; assign if0.out_ready = out_ready;

  vector100r_deser #(.W(W), .REVERSE(1'b1)) dut1 (.clk(clk), .reset(reset), .bus(if1));
  vector100r_deser #(.W(W), .REVERSE(1'b0)) dut0 (.clk(clk), .reset(reset), .bus(if0));

  int checks = 0;
  int errors = 0;

  // reference model: words kept in "bit k at index k" orientation
  bit           q[$];
  logic [W-1:0] e_out = '0, e_pword = '0;
  bit           e_valid = 0, e_pend = 0, e_abort = 0;

  int cyc = 0, nvalid = 0, naborts = 0, nlow = 0;
  int vt[$];

  function automatic logic [W-1:0] rev(input logic [W-1:0] w);
    logic [W-1:0] r;
    for (int k = 0; k < W; k++) r[W-1-k] = w[k];
    return r;
  endfunction

  task automatic model_reset();
    q.delete();
    e_out = '0; e_pword = '0; e_valid = 0; e_pend = 0; e_abort = 0;
  endtask

  task automatic model_step();
    bit xfer, acc, done;
    logic [W-1:0] word;
    xfer = e_valid && out_ready;
    acc  = in_valid && !e_pend;
    done = 0;
    e_abort = 0;
    word = '0;
    if (acc) begin
      if (in_start && q.size() != 0) begin
        q.delete();
        e_abort = 1;
      end
      q.push_back(in_bit);
      if (q.size() == W) begin
        for (int k = 0; k < W; k++) word[k] = q[k];
        q.delete();
        done = 1;
      end
    end
    if (e_pend && xfer) begin
      e_out = e_pword;
      e_pend = 0;
    end else if (done) begin
      if (!e_valid || xfer) begin
        e_out = word;
        e_valid = 1;
      end else begin
        e_pword = word;
        e_pend = 1;
      end
    end else if (xfer) begin
      e_valid = 0;
    end
  endtask

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    checks++;
    assert (obs == exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk1("r1_valid", if1.out_valid, e_valid);
    chk1("r1_ready", if1.in_ready, !e_pend);
    chk1("r1_abort", if1.abort_err, e_abort);
    chk ("r1_out", if1.out, e_out);
    chk1("r0_valid", if0.out_valid, e_valid);
    chk1("r0_ready", if0.in_ready, !e_pend);
    chk1("r0_abort", if0.abort_err, e_abort);
    chk ("r0_out", if0.out, rev(e_out));
    if (if1.out_valid) begin nvalid++; vt.push_back(cyc); end
    if (if1.abort_err) naborts++;
    if (!if1.in_ready) nlow++;
  endtask

  task automatic cycle(input logic v, input logic b, input logic s, input logic r);
    in_valid = v; in_bit = b; in_start = s; out_ready = r;
    @(posedge clk);
    cyc++;
    if (reset) model_reset(); else model_step();
    #1;
    check_all();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
  endtask

  task automatic send_word(input logic [W-1:0] w, input logic r);
    for (int k = 0; k < W; k++) cycle(1'b1, w[k], k == 0, r);
  endtask

  function automatic logic [W-1:0] rand_word();
    logic [W-1:0] w;
    for (int k = 0; k < W; k++) w[k] = 1'($urandom_range(0, 1));
    return w;
  endfunction

  logic [W-1:0] pat, msb, wa, wb, wd;

  initial begin
    // reset state
    do_reset();
    chk ("rst_out", if1.out, '0);
    chk1("rst_valid", if1.out_valid, 1'b0);
    chk1("rst_ready", if1.in_ready, 1'b1);
    chk1("rst_abort", if1.abort_err, 1'b0);

    // symmetric pattern: identical under both bit orders
    pat = '0; pat[0] = 1'b1; pat[W-1] = 1'b1;
    send_word(pat, 1'b1);
    chk1("t1_valid", if1.out_valid, 1'b1);
    chk ("t1_out_rev1", if1.out, 100'h8_0000_0000_0000_0000_0000_0001);
    chk ("t1_out_rev0", if0.out, 100'h8_0000_0000_0000_0000_0000_0001);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    chk1("t1_valid_drop", if1.out_valid, 1'b0);

    // only the first bit set
    pat = '0; pat[0] = 1'b1;
    msb = '0; msb[W-1] = 1'b1;
    send_word(pat, 1'b1);
    chk("t2_rev1", if1.out, pat);
    chk("t2_rev0", if0.out, msb);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);

    // backpressure: A held, B parked, in_ready drops
    wa = '1;
    for (int k = 0; k < W; k++) wb[k] = (k % 2 == 0);
    send_word(wa, 1'b0);
    send_word(wb, 1'b0);
    chk ("bp_hold_a", if1.out, wa);
    chk1("bp_ready_low", if1.in_ready, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    chk ("bp_still_a", if1.out, wa);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    chk ("bp_out_b", if1.out, wb);
    chk1("bp_valid_b", if1.out_valid, 1'b1);
    chk1("bp_ready_back", if1.in_ready, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    chk ("bp_hold_b", if1.out, wb);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);

    // abort: 37 bits, restart, 99 more bits
    nvalid = 0; naborts = 0;
    for (int k = 0; k < 37; k++) cycle(1'b1, 1'($urandom_range(0, 1)), k == 0, 1'b1);
    wd = rand_word();
    for (int k = 0; k < W; k++) cycle(1'b1, wd[k], k == 0, 1'b1);
    chk ("ab_word", if1.out, wd);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    chki("ab_pulses", naborts, 1);
    chki("ab_words", nvalid, 1);

    // reset mid-word
    for (int k = 0; k < 50; k++) cycle(1'b1, 1'($urandom_range(0, 1)), k == 0, 1'b1);
    do_reset();
    chk ("mr_out", if1.out, '0);
    chk1("mr_valid", if1.out_valid, 1'b0);
    chk1("mr_ready", if1.in_ready, 1'b1);
    chk1("mr_abort", if1.abort_err, 1'b0);
    wd = rand_word();
    send_word(wd, 1'b1);
    chk("mr_word", if1.out, wd);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);

    // streaming: 4 back-to-back words
    vt.delete(); nlow = 0;
    for (int n = 0; n < 4; n++) send_word(rand_word(), 1'b1);
    chki("st_count", vt.size(), 4);
    if (vt.size() == 4)
      for (int n = 1; n < 4; n++) chki("st_interval", vt[n] - vt[n-1], W);
    chki("st_ready_low", nlow, 0);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);

    // random traffic against the model
    for (int n = 0; n < 3000; n++)
      cycle(1'($urandom_range(0, 9) < 8), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 299) == 0), 1'($urandom_range(0, 3) != 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
